hall_conditioner: RTL and testbench
===================================

# hall_conditioner

Front end of the BLDC commutation path. Synchronises and debounces the three raw Hall-sensor inputs and decodes them into a rotor sector (0..5). Flags direction, commutation steps, illegal codes and skipped sectors, and measures the step period for speed estimation. Its SECTOR/VALID/FAULT outputs feed the commutation/PWM stage that drives the A/B/C high-side and AA/BB/CC low-side gates.

## Interface
- FILT_CYCLES, 16: consecutive cycles a new synchronised Hall code must hold before it is accepted (≥1).
- PERIOD_W, 20: width of the step-period counter and the PERIOD output.

- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- H1, H2, H3  in  1 each  raw Hall inputs, asynchronous to CLK.
- SECTOR  out  3  decoded sector 0..5; 7 = unknown/illegal.
- VALID  out  1  SECTOR holds a legal sector.
- STEP  out  1  one-cycle pulse on each accepted legal sector change.
- DIR  out  1  1 = forward (sector +1 mod 6), 0 = reverse (sector −1 mod 6).
- PERIOD  out  PERIOD_W  CLK cycles between the last two steps, saturating.
- PERIOD_VLD  out  1  one-cycle pulse when PERIOD is updated.
- STALL  out  1  no step for 2^PERIOD_W−1 cycles.
- FAULT  out  1  sticky flag for an illegal code or a skipped sector; cleared only by RST.

## Operation
- Code is {H3,H2,H1}. Forward sequence and sector: 001→0, 101→1, 100→2, 110→3, 010→4, 011→5. Codes 000 and 111 are illegal.
- Two-flop synchroniser per pin. Debounce compares the synchronised code with the accepted code; a differing code must stay identical for FILT_CYCLES consecutive cycles before it is accepted. Any change during counting restarts the count with the new value.
- The accepted code is decoded in the cycle after acceptance:
  - Illegal code: SECTOR=7, VALID=0, FAULT=1. STEP, DIR and period are unchanged.
  - Legal code, first since reset or since an illegal code: SECTOR and VALID=1 are loaded. There is no STEP, DIR is unchanged and the period reference is restarted.
  - Legal code, delta = new−old mod 6 equal to 1: STEP=1, DIR=1.
  - Legal code, delta equal to 5: STEP=1, DIR=0.
  - Legal code, delta of 2, 3 or 4: SECTOR is updated and FAULT=1. There is no STEP and the period reference is restarted.
- Period counter:
  - Increments every cycle and saturates at 2^PERIOD_W−1.
  - On STEP: PERIOD ← count+1 (saturated), PERIOD_VLD=1 and the count is reset to 0. This happens only if a reference step exists and STALL=0; otherwise the step just establishes the reference.
  - STALL is set when the count saturates and is cleared on the next STEP; that STEP does not assert PERIOD_VLD.
- Reset values: SECTOR=7, VALID=0, STEP=0, DIR=1, PERIOD=0, PERIOD_VLD=0, STALL=0, FAULT=0. Synchroniser and accepted code are 000, flagged "no position" (no fault). The count is 0 and there is no reference.
- RST asserted mid-debounce or mid-period discards all in-flight state. The next accepted code is treated as first.

## Timing
- Latency from the first CLK edge that samples a new stable pin level to the SECTOR/STEP update is exactly FILT_CYCLES+3 edges: 2 synchroniser edges, FILT_CYCLES filter edges and 1 decode edge.
- STEP, PERIOD_VLD and the SECTOR change occur in the same cycle. PERIOD is stable until the next PERIOD_VLD.
- Glitches shorter than FILT_CYCLES cycles after synchronisation produce no output change.
- Simultaneous multi-pin changes are treated as a single code change and are decoded by the delta rule.

## Configuration
- HALL_PERIOD_EN defined: period counter, PERIOD, PERIOD_VLD and STALL are implemented as above.
- HALL_PERIOD_EN undefined: no counter is built. PERIOD is tied to 0 and PERIOD_VLD and STALL to 0. All ports remain present. Sector, STEP, DIR and FAULT behaviour is unchanged.

## Structure
- Package hall_pkg holds:
  - the SECTOR_INVALID=3'd7 constant;
  - the code→sector lookup function, with illegal codes mapping to 7;
  - the forward-sequence code constants.
- Sub-module hall_filter: the 3-bit two-flop synchroniser plus FILT_CYCLES debounce. It outputs the accepted code and a one-cycle "accepted" strobe.
- Decode, direction, fault and period logic live in hall_conditioner.

## Test plan
All scenarios use FILT_CYCLES=4 and PERIOD_W=8.
- Reset, then hold 001 → SECTOR 7 → 0 and VALID=1 exactly 7 edges after the first sample, with no STEP and FAULT=0.
- Forward rotation 001,101,100,110,010,011 with 50 cycles per step → STEP on each change and DIR=1. The first step gives no PERIOD_VLD; every later step gives PERIOD=50 with PERIOD_VLD.
- Reverse sequence 011,010,110 → STEP pulses with DIR=0 and SECTOR 5→4→3.
- A 3-cycle glitch 001→101→001 → no SECTOR change and no STEP. Then 100 from sector 0 → SECTOR=2, FAULT=1 and no STEP.
- Code 111 held 10 cycles → SECTOR=7, VALID=0 and FAULT=1 sticky. The next legal code gives VALID=1 with no STEP, and FAULT stays 1 until RST.
- No edge for 255 cycles → STALL=1. The next step clears STALL with no PERIOD_VLD. With HALL_PERIOD_EN undefined, PERIOD, PERIOD_VLD and STALL stay 0 throughout.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared Hall-sensor code and sector definitions for the commutation front end.
package hall_pkg;

    localparam logic [2:0] SECTOR_INVALID = 3'd7;

    localparam logic [2:0] CODE_S0 = 3'b001;
    localparam logic [2:0] CODE_S1 = 3'b101;
    localparam logic [2:0] CODE_S2 = 3'b100;
    localparam logic [2:0] CODE_S3 = 3'b110;
    localparam logic [2:0] CODE_S4 = 3'b010;
    localparam logic [2:0] CODE_S5 = 3'b011;

    typedef struct packed {
        logic [2:0] sector;
        logic       valid;
        logic       step;
        logic       dir;
        logic       fault;
    } pos_t;

    localparam pos_t POS_RESET = '{
        sector: SECTOR_INVALID,
        valid:  1'b0,
        step:   1'b0,
        dir:    1'b1,
        fault:  1'b0
    };

    function automatic logic [2:0] code_to_sector(input logic [2:0] code);
        logic [2:0] s;
        case (code)
            CODE_S0: s = 3'd0;
            CODE_S1: s = 3'd1;
            CODE_S2: s = 3'd2;
            CODE_S3: s = 3'd3;
            CODE_S4: s = 3'd4;
            CODE_S5: s = 3'd5;
            default: s = SECTOR_INVALID;
        endcase
        return s;
    endfunction

    // (new - old) mod 6; only meaningful for two legal sectors
    function automatic logic [2:0] sector_delta(input logic [2:0] nw,
                                                input logic [2:0] od);
        logic [3:0] d;
        d = {1'b0, nw} + 4'd6 - {1'b0, od};
        if (d >= 4'd6) d = d - 4'd6;
        return d[2:0];
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser and debounce for the 3-bit Hall code.
module hall_filter
    import hall_pkg::*;
#(
    parameter int FILT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall_raw,
    output logic [2:0] code,
    output logic       accept
);

    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_nxt;
    logic          accept_q, accept_d;

    always_comb begin
        sync1_d  = hall_raw;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        cnt_nxt  = (sync2_q != cand_q) ? CW'(1) : cnt_q + 1'b1;
        if (sync2_q == acc_q) begin
            cand_d = acc_q;
            cnt_d  = '0;
        end else if (cnt_nxt == CW'(FILT_CYCLES)) begin
            acc_d    = sync2_q;
            cand_d   = sync2_q;
            cnt_d    = '0;
            accept_d = 1'b1;
        end else begin
            cand_d = sync2_q;
            cnt_d  = cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign code   = acc_q;
    assign accept = accept_q;

endmodule

// File: rtl/hall_conditioner.sv
// Hall sensor decode, direction, fault and step-period measurement.
// Period counter/STALL built only when HALL_PERIOD_EN is defined.
module hall_conditioner
    import hall_pkg::*;
#(
    parameter int FILT_CYCLES = 16,
    parameter int PERIOD_W    = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                H1,
    input  logic                H2,
    input  logic                H3,
    output logic [2:0]          SECTOR,
    output logic                VALID,
    output logic                STEP,
    output logic                DIR,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic                PERIOD_VLD,
    output logic                STALL,
    output logic                FAULT
);

    logic [2:0] acc_code;
    logic       accept;
    logic [2:0] new_sector;
    logic [2:0] delta;
    pos_t       pos_q, pos_d;

    hall_filter #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filter (
        .clk     (CLK),
        .rst     (RST),
        .hall_raw({H3, H2, H1}),
        .code    (acc_code),
        .accept  (accept)
    );

    always_comb begin
        new_sector = code_to_sector(acc_code);
        delta      = sector_delta(new_sector, pos_q.sector);
        pos_d      = pos_q;
        pos_d.step = 1'b0;
        if (accept) begin
            if (new_sector == SECTOR_INVALID) begin
                pos_d.sector = SECTOR_INVALID;
                pos_d.valid  = 1'b0;
                pos_d.fault  = 1'b1;
            end else if (!pos_q.valid) begin
                pos_d.sector = new_sector;
                pos_d.valid  = 1'b1;
            end else if (delta == 3'd1) begin
                pos_d.sector = new_sector;
                pos_d.step   = 1'b1;
                pos_d.dir    = 1'b1;
            end else if (delta == 3'd5) begin
                pos_d.sector = new_sector;
                pos_d.step   = 1'b1;
                pos_d.dir    = 1'b0;
            end else if (delta != 3'd0) begin
                pos_d.sector = new_sector;
                pos_d.fault  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) pos_q <= POS_RESET;
        else     pos_q <= pos_d;
    end

    assign SECTOR = pos_q.sector;
    assign VALID  = pos_q.valid;
    assign STEP   = pos_q.step;
    assign DIR    = pos_q.dir;
    assign FAULT  = pos_q.fault;

`ifdef HALL_PERIOD_EN
    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

    logic                restart;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pvld_q, pvld_d;
    logic                ref_q, ref_d;
    logic                stall_q, stall_d;

    // first legal code or a skipped sector drops the timing reference
    assign restart = accept && (new_sector != SECTOR_INVALID) &&
                     (!pos_q.valid ||
                      ((delta != 3'd1) && (delta != 3'd5) && (delta != 3'd0)));

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        pvld_d   = 1'b0;
        ref_d    = ref_q;
        stall_d  = stall_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        else                  stall_d = 1'b1;
        if (pos_d.step) begin
            if (ref_q && !stall_q) begin
                period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                pvld_d   = 1'b1;
            end
            ref_d   = 1'b1;
            stall_d = 1'b0;
            cnt_d   = '0;
        end else if (restart) begin
            ref_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            period_q <= '0;
            pvld_q   <= 1'b0;
            ref_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pvld_q   <= pvld_d;
            ref_q    <= ref_d;
            stall_q  <= stall_d;
        end
    end

    assign PERIOD     = period_q;
    assign PERIOD_VLD = pvld_q;
    assign STALL      = stall_q;
`else
    assign PERIOD     = '0;
    assign PERIOD_VLD = 1'b0;
    assign STALL      = 1'b0;
`endif

endmodule

// File: tb/tb_hall_conditioner.sv
// Directed vector bench for hall_conditioner (FILT_CYCLES=4, PERIOD_W=8).
module tb_hall_conditioner;

`ifdef HALL_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int P50 = PEN ? 50 : 0;
    localparam int PV  = PEN ? 1 : 0;

    logic       CLK = 1'b0;
    logic       rst;
    logic [2:0] hall;
    logic [2:0] SECTOR;
    logic       VALID, STEP, DIR, PERIOD_VLD, STALL, FAULT;
    logic [7:0] PERIOD;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    hall_conditioner #(
        .FILT_CYCLES(4),
        .PERIOD_W   (8)
    ) dut (
        .CLK       (CLK),
        .RST       (rst),
        .H1        (hall[0]),
        .H2        (hall[1]),
        .H3        (hall[2]),
        .SECTOR    (SECTOR),
        .VALID     (VALID),
        .STEP      (STEP),
        .DIR       (DIR),
        .PERIOD    (PERIOD),
        .PERIOD_VLD(PERIOD_VLD),
        .STALL     (STALL),
        .FAULT     (FAULT)
    );

    typedef struct {
        logic [2:0] code;
        int         hold;
        bit         rst;
        logic [2:0] sec;
        bit         vld;
        int         steps;
        bit         dir;
        int         pv;
        int         per;
        bit         stall;
        bit         fault;
    } vec_t;

    function automatic vec_t mk(logic [2:0] c, int h, bit r, logic [2:0] s,
                                bit v, int st, bit d, int pv, int per,
                                bit sl, bit f);
        vec_t t;
        t.code = c; t.hold = h; t.rst = r; t.sec = s; t.vld = v;
        t.steps = st; t.dir = d; t.pv = pv; t.per = per;
        t.stall = sl; t.fault = f;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [2:0] c, input int n,
                       output int st, output int pv);
        hall = c;
        st = 0;
        pv = 0;
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (STEP) st++;
            if (PERIOD_VLD) pv++;
        end
    endtask

    vec_t tbl[19];
    int   st, pv;

    initial begin
        tbl[0]  = mk(3'b101, 50, 0, 3'd1, 1, 1, 1, 0,  0,   0,   0);
        tbl[1]  = mk(3'b100, 50, 0, 3'd2, 1, 1, 1, PV, P50, 0,   0);
        tbl[2]  = mk(3'b110, 50, 0, 3'd3, 1, 1, 1, PV, P50, 0,   0);
        tbl[3]  = mk(3'b010, 50, 0, 3'd4, 1, 1, 1, PV, P50, 0,   0);
        tbl[4]  = mk(3'b011, 50, 0, 3'd5, 1, 1, 1, PV, P50, 0,   0);
        tbl[5]  = mk(3'b010, 50, 0, 3'd4, 1, 1, 0, PV, P50, 0,   0);
        tbl[6]  = mk(3'b110, 50, 0, 3'd3, 1, 1, 0, PV, P50, 0,   0);
        tbl[7]  = mk(3'b001, 3,  1, 3'd7, 0, 0, 1, 0,  0,   0,   0);
        tbl[8]  = mk(3'b001, 20, 0, 3'd0, 1, 0, 1, 0,  0,   0,   0);
        tbl[9]  = mk(3'b100, 20, 0, 3'd2, 1, 0, 1, 0,  0,   0,   1);
        tbl[10] = mk(3'b111, 10, 0, 3'd7, 0, 0, 1, 0,  0,   0,   1);
        tbl[11] = mk(3'b110, 20, 0, 3'd3, 1, 0, 1, 0,  0,   0,   1);
        tbl[12] = mk(3'b010, 20, 0, 3'd4, 1, 1, 1, 0,  0,   0,   1);
        tbl[13] = mk(3'b010, 3,  1, 3'd7, 0, 0, 1, 0,  0,   0,   0);
        tbl[14] = mk(3'b001, 50, 0, 3'd0, 1, 0, 1, 0,  0,   0,   0);
        tbl[15] = mk(3'b101, 50, 0, 3'd1, 1, 1, 1, 0,  0,   0,   0);
        tbl[16] = mk(3'b101, 300,0, 3'd1, 1, 0, 1, 0,  0,   PEN, 0);
        tbl[17] = mk(3'b100, 50, 0, 3'd2, 1, 1, 1, 0,  0,   0,   0);
        tbl[18] = mk(3'b110, 50, 0, 3'd3, 1, 1, 1, PV, P50, 0,   0);

        rst  = 1'b1;
        hall = 3'b000;
        run(3'b000, 3, st, pv);
        chk("rst_sector", int'(SECTOR), 7);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_step", int'(STEP), 0);
        chk("rst_dir", int'(DIR), 1);
        chk("rst_period", int'(PERIOD), 0);
        chk("rst_pvld", int'(PERIOD_VLD), 0);
        chk("rst_stall", int'(STALL), 0);
        chk("rst_fault", int'(FAULT), 0);
        rst = 1'b0;

        // first legal code appears exactly 7 edges after it is first sampled
        hall = 3'b001;
        st = 0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge CLK);
            #1;
            if (STEP) st++;
            if (e == 6) chk("lat_e6_sector", int'(SECTOR), 7);
        end
        chk("lat_e7_sector", int'(SECTOR), 0);
        chk("lat_e7_valid", int'(VALID), 1);
        chk("lat_steps", st, 0);
        chk("lat_fault", int'(FAULT), 0);
        run(3'b001, 43, st, pv);

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst;
            run(tbl[i].code, tbl[i].hold, st, pv);
            chk($sformatf("row%0d_sector", i), int'(SECTOR), int'(tbl[i].sec));
            chk($sformatf("row%0d_valid", i), int'(VALID), int'(tbl[i].vld));
            chk($sformatf("row%0d_steps", i), st, tbl[i].steps);
            chk($sformatf("row%0d_dir", i), int'(DIR), int'(tbl[i].dir));
            chk($sformatf("row%0d_pvld", i), pv, tbl[i].pv);
            chk($sformatf("row%0d_period", i), int'(PERIOD), tbl[i].per);
            chk($sformatf("row%0d_stall", i), int'(STALL), int'(tbl[i].stall));
            chk($sformatf("row%0d_fault", i), int'(FAULT), int'(tbl[i].fault));
            rst = 1'b0;

            if (i == 8) begin
                int gs, gp;
                run(3'b101, 3, gs, gp);
                run(3'b001, 20, st, pv);
                chk("glitch_steps", gs + st, 0);
                chk("glitch_sector", int'(SECTOR), 0);
                chk("glitch_valid", int'(VALID), 1);
                chk("glitch_fault", int'(FAULT), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
